// File: rtl/hack_decode_ctrl.sv
// Hack instruction register + decode/control stage sitting after the ROM/PC block.
// Latency: a fetched word reaches IR one edge after rom_dout shows it and executes that cycle.
// Backpressure: M-read instructions hold the ROM one cycle via rom_stall; taken jumps squash one word.
//
// Ports:
//   a_clk, a_reset        clock, synchronous active-high reset
//   rom_dout              instruction word from ROM (one cycle after its address)
//   rom_jmp/rom_addr      PC load request and target toward the ROM
//   rom_stall             ask the ROM to re-present its current word next cycle
//   a_val, zr, ng         A register value and ALU flags for the instruction in IR
//   mem_rd                RAM read at address A, data expected next cycle
//   ex_*                  decoded fields for the execute datapath
//   retired               wrapping count of executed instructions
module hack_decode_ctrl #(
  parameter int IL = 16
) (
  input  logic          a_clk,
  input  logic          a_reset,
  input  logic [IL-1:0] rom_dout,
  output logic          rom_jmp,
  output logic          rom_stall,
  output logic [IL-2:0] rom_addr,
  input  logic [IL-1:0] a_val,
  input  logic          zr,
  input  logic          ng,
  output logic          mem_rd,
  output logic          ex_valid,
  output logic          ex_is_a,
  output logic [IL-2:0] ex_imm,
  output logic          ex_sel_m,
  output logic [5:0]    ex_alu,
  output logic [2:0]    ex_dest,
  output logic [15:0]   retired
);

  typedef enum logic {
    RUN   = 1'b0,
    MEXEC = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IL-1:0] ir;
  logic          ir_valid;
  logic [15:0]   retired_q;

  logic          ir_is_c;
  logic          ir_a_bit;
  logic [2:0]    ir_jmp;
  logic          jmp_cond;
  logic          take;
  logic          ex_vld_c;
  logic          stall_c;
  logic          mem_rd_c;

  // The top bit of A is plain data; code addresses only span IL-1 bits.
  logic          unused_a_msb;
  assign unused_a_msb = a_val[IL-1];

  assign ir_is_c  = ir[IL-1];
  assign ir_a_bit = ir[12];
  assign ir_jmp   = ir[2:0];

  // j1 = less than zero, j2 = equal to zero, j3 = greater than zero.
  assign jmp_cond = (ir_jmp[2] & ng) |
                    (ir_jmp[1] & zr) |
                    (ir_jmp[0] & ~zr & ~ng);

  // Control FSM. An M-reading C-instruction spends one cycle in RUN issuing
  // the RAM read with execution suppressed, then executes in MEXEC once the
  // RAM data is back. Jumps can only resolve in a cycle that executes.
  always_comb begin
    state_nxt = state;
    ex_vld_c  = 1'b0;
    stall_c   = 1'b0;
    mem_rd_c  = 1'b0;
    if (a_reset) begin
      state_nxt = RUN;
    end else if (!ir_valid) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN: begin
          if (ir_is_c && ir_a_bit) begin
            stall_c   = 1'b1;
            mem_rd_c  = 1'b1;
            state_nxt = MEXEC;
          end else begin
            ex_vld_c = 1'b1;
          end
        end
        MEXEC: begin
          ex_vld_c  = 1'b1;
          state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // ex_vld_c is never set together with stall_c, so a jump and a stall
  // cannot be requested in the same cycle.
  assign take = ex_vld_c & ir_is_c & jmp_cond;

  // During reset the ROM is steered to address 0 so ROM[0] is waiting on
  // rom_dout in the first cycle after release.
  assign rom_jmp   = a_reset | take;
  assign rom_addr  = a_reset ? '0 : a_val[IL-2:0];
  assign rom_stall = stall_c;
  assign mem_rd    = mem_rd_c;

  // IR follows rom_dout except while the ROM is being held for an M read;
  // the ROM re-presents the same word, so nothing is lost.
  always_ff @(posedge a_clk) begin
    if (!stall_c) begin
      ir <= rom_dout;
    end
  end

  always_ff @(posedge a_clk) begin
    if (a_reset) begin
      state     <= RUN;
      ir_valid  <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      // The word captured on a taken-jump edge is the fall-through and must
      // not execute.
      if (!stall_c) begin
        ir_valid <= ~take;
      end
      if (ex_vld_c) begin
        retired_q <= retired_q + 16'd1;
      end
    end
  end

  assign ex_valid = ex_vld_c;
  assign ex_is_a  = ~ir_is_c;
  assign ex_imm   = ir[IL-2:0];
  assign ex_sel_m = ir_a_bit;
  assign ex_alu   = ir[11:6];
  assign ex_dest  = ir[5:3] & {3{ex_vld_c}};
  assign retired  = retired_q;

endmodule

// File: tb/tb_hack_decode_ctrl.sv
module tb_hack_decode_ctrl;

  logic        a_clk = 1'b0;
  logic        a_reset;
  logic [15:0] rom_dout = 16'h0000;
  logic        rom_jmp;
  logic        rom_stall;
  logic [14:0] rom_addr;
  logic [15:0] a_val;
  logic        zr;
  logic        ng;
  logic        mem_rd;
  logic        ex_valid;
  logic        ex_is_a;
  logic [14:0] ex_imm;
  logic        ex_sel_m;
  logic [5:0]  ex_alu;
  logic [2:0]  ex_dest;
  logic [15:0] retired;

  int checks = 0;
  int errors = 0;
  int row_no = 0;

  hack_decode_ctrl #(.IL(16)) dut (
    .a_clk    (a_clk),
    .a_reset  (a_reset),
    .rom_dout (rom_dout),
    .rom_jmp  (rom_jmp),
    .rom_stall(rom_stall),
    .rom_addr (rom_addr),
    .a_val    (a_val),
    .zr       (zr),
    .ng       (ng),
    .mem_rd   (mem_rd),
    .ex_valid (ex_valid),
    .ex_is_a  (ex_is_a),
    .ex_imm   (ex_imm),
    .ex_sel_m (ex_sel_m),
    .ex_alu   (ex_alu),
    .ex_dest  (ex_dest),
    .retired  (retired)
  );

  always #5 a_clk = ~a_clk;

  // Program ROM with PC: jump target is used as the read address directly,
  // stall holds both PC and the output word.
  logic [15:0] prog [0:63];
  logic [5:0]  pc = 6'd0;

  always @(posedge a_clk) begin
    if (!rom_stall) begin
      if (rom_jmp) begin
        rom_dout <= prog[rom_addr[5:0]];
        pc       <= rom_addr[5:0] + 6'd1;
      end else begin
        rom_dout <= prog[pc];
        pc       <= pc + 6'd1;
      end
    end
  end

  typedef struct packed {
    logic        rst;
    logic [15:0] a_val;
    logic        zr;
    logic        ng;
    logic        vld;
    logic        jmp;
    logic [14:0] addr;
    logic        stall;
    logic        mrd;
    logic        chk_ir;
    logic [15:0] ir;
    logic [2:0]  dest;
    logic [15:0] ret;
  } vec_t;

  vec_t sb [$];
  vec_t tbl [19];

  function automatic vec_t mk(input logic rst, input logic [15:0] av, input logic z,
                              input logic n, input logic vld, input logic jmp,
                              input logic [14:0] addr, input logic stall, input logic mrd,
                              input logic chk_ir, input logic [15:0] ir,
                              input logic [2:0] dest, input logic [15:0] ret);
    vec_t v;
    v.rst = rst; v.a_val = av; v.zr = z; v.ng = n;
    v.vld = vld; v.jmp = jmp; v.addr = addr; v.stall = stall; v.mrd = mrd;
    v.chk_ir = chk_ir; v.ir = ir; v.dest = dest; v.ret = ret;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row_no, act, exp);
    end
  endtask

  task automatic check_row();
    vec_t e;
    e = sb.pop_front();
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.vld});
    chk("rom_jmp", {31'd0, rom_jmp}, {31'd0, e.jmp});
    chk("rom_stall", {31'd0, rom_stall}, {31'd0, e.stall});
    chk("mem_rd", {31'd0, mem_rd}, {31'd0, e.mrd});
    chk("retired", {16'd0, retired}, {16'd0, e.ret});
    chk("jmp_stall_excl", {31'd0, rom_jmp & rom_stall}, 32'd0);
    if (e.jmp)
      chk("rom_addr", {17'd0, rom_addr}, {17'd0, e.addr});
    if (e.chk_ir)
      chk("ir_fields", {9'd0, ex_is_a, ex_imm, ex_sel_m, ex_alu},
          {9'd0, ~e.ir[15], e.ir[14:0], e.ir[12], e.ir[11:6]});
    // A-instructions executing carry immediate bits in the dest field.
    if (!(e.vld && !e.ir[15]))
      chk("ex_dest", {29'd0, ex_dest}, {29'd0, e.dest});
    row_no++;
  endtask

  task automatic apply(input vec_t v);
    @(negedge a_clk);
    a_reset = v.rst;
    a_val   = v.a_val;
    zr      = v.zr;
    ng      = v.ng;
    sb.push_back(v);
    #2;
    check_row();
  endtask

  initial begin
    a_reset = 1'b1;
    a_val   = 16'h0000;
    zr      = 1'b0;
    ng      = 1'b0;

    for (int i = 0; i < 64; i++) prog[i] = 16'h0063;
    prog[0]  = 16'h0005;  // @5
    prog[1]  = 16'h0007;  // @7
    prog[2]  = 16'h0009;  // @9
    prog[3]  = 16'h0014;  // @20
    prog[4]  = 16'hEA87;  // 0;JMP
    prog[20] = 16'hE302;  // D;JEQ
    prog[21] = 16'h000B;  // @11
    prog[22] = 16'hFC10;  // D=M
    prog[23] = 16'h000C;  // @12
    prog[24] = 16'hFC12;  // D=M;JEQ
    prog[25] = 16'h000D;  // @13, squashed
    prog[48] = 16'h000E;  // @14
    prog[49] = 16'hFC12;  // D=M;JEQ, reset hits its stall cycle
    prog[50] = 16'h000F;

    //            rst av        z  n  vld jmp addr      st mr ck ir        dest    ret
    tbl[0]  = mk(1, 16'h0000, 0, 0, 0, 1, 15'h0000, 0, 0, 0, 16'h0000, 3'b000, 16'd0);
    tbl[1]  = mk(1, 16'h0000, 0, 0, 0, 1, 15'h0000, 0, 0, 0, 16'h0000, 3'b000, 16'd0);
    tbl[2]  = mk(0, 16'h0000, 0, 0, 0, 0, 15'h0000, 0, 0, 0, 16'h0000, 3'b000, 16'd0);
    tbl[3]  = mk(0, 16'h0000, 0, 1, 1, 0, 15'h0000, 0, 0, 1, 16'h0005, 3'b000, 16'd0);
    tbl[4]  = mk(0, 16'h0005, 0, 0, 1, 0, 15'h0000, 0, 0, 1, 16'h0007, 3'b000, 16'd1);
    tbl[5]  = mk(0, 16'h0007, 0, 0, 1, 0, 15'h0000, 0, 0, 1, 16'h0009, 3'b000, 16'd2);
    tbl[6]  = mk(0, 16'h0009, 0, 1, 1, 0, 15'h0000, 0, 0, 1, 16'h0014, 3'b000, 16'd3);
    tbl[7]  = mk(0, 16'h0014, 1, 0, 1, 1, 15'h0014, 0, 0, 1, 16'hEA87, 3'b000, 16'd4);
    tbl[8]  = mk(0, 16'h0014, 1, 0, 0, 0, 15'h0000, 0, 0, 1, 16'h0063, 3'b000, 16'd5);
    tbl[9]  = mk(0, 16'h0014, 0, 0, 1, 0, 15'h0000, 0, 0, 1, 16'hE302, 3'b000, 16'd5);
    tbl[10] = mk(0, 16'h0014, 0, 0, 1, 0, 15'h0000, 0, 0, 1, 16'h000B, 3'b000, 16'd6);
    tbl[11] = mk(0, 16'h000B, 0, 0, 0, 0, 15'h0000, 1, 1, 1, 16'hFC10, 3'b000, 16'd7);
    tbl[12] = mk(0, 16'h000B, 0, 0, 1, 0, 15'h0000, 0, 0, 1, 16'hFC10, 3'b010, 16'd7);
    tbl[13] = mk(0, 16'h000B, 0, 0, 1, 0, 15'h0000, 0, 0, 1, 16'h000C, 3'b000, 16'd8);
    tbl[14] = mk(0, 16'h0030, 1, 0, 0, 0, 15'h0000, 1, 1, 1, 16'hFC12, 3'b000, 16'd9);
    tbl[15] = mk(0, 16'h0030, 1, 0, 1, 1, 15'h0030, 0, 0, 1, 16'hFC12, 3'b010, 16'd9);
    tbl[16] = mk(0, 16'h0030, 0, 1, 0, 0, 15'h0000, 0, 0, 1, 16'h000D, 3'b000, 16'd10);
    tbl[17] = mk(0, 16'h0030, 0, 0, 1, 0, 15'h0000, 0, 0, 1, 16'h000E, 3'b000, 16'd10);
    tbl[18] = mk(0, 16'h000E, 1, 0, 0, 0, 15'h0000, 1, 1, 1, 16'hFC12, 3'b000, 16'd11);

    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // Reset arrives late in the stall cycle of the second D=M;JEQ.
    #1 a_reset = 1'b1;
    apply(mk(1, 16'h000E, 1, 0, 0, 1, 15'h0000, 0, 0, 0, 16'h0000, 3'b000, 16'd0));
    apply(mk(0, 16'h0000, 0, 0, 0, 0, 15'h0000, 0, 0, 0, 16'h0000, 3'b000, 16'd0));
    apply(mk(0, 16'h0000, 0, 1, 1, 0, 15'h0000, 0, 0, 1, 16'h0005, 3'b000, 16'd0));
    apply(mk(0, 16'h0005, 0, 0, 1, 0, 15'h0000, 0, 0, 1, 16'h0007, 3'b000, 16'd1));

    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_decode_ctrl.md
# hack_decode_ctrl

Instruction-register and control stage directly downstream of the program ROM/PC block. It captures each fetched Hack instruction and decodes it for the execute datapath. It resolves jumps using the ALU flags and inserts a one-cycle stall for every instruction that reads M. It drives the ROM's `jmp`, `stall` and jump-address inputs, which closes the fetch loop.

## Interface
- `IL`, 16, instruction width; the ROM address width is IL-1.
- `a_clk`  in  1  system clock; all state updates on the rising edge.
- `a_reset`  in  1  synchronous, active-high reset.
- `rom_dout`  in  IL  instruction word from the ROM, valid every cycle, one cycle after its address.
- `rom_jmp`  out  1  to ROM `jmp`: load the PC from `rom_addr` this cycle.
- `rom_stall`  out  1  to ROM `stall`: re-present the current word next cycle.
- `rom_addr`  out  IL-1  to ROM address input: jump target.
- `a_val`  in  IL  current A register value. Low IL-1 bits are the jump target.
- `zr`, `ng`  in  1 each  ALU flags for the instruction in IR, valid combinationally in the same cycle.
- `mem_rd`  out  1  RAM read request at address A; data is expected the next cycle.
- `ex_valid`  out  1  IR instruction executes this cycle (register writes allowed).
- `ex_is_a`  out  1  IR holds an A-instruction (bit IL-1 = 0).
- `ex_imm`  out  IL-1  A-instruction immediate, IR[IL-2:0].
- `ex_sel_m`  out  1  ALU y operand is M (a bit, IR[12]).
- `ex_alu`  out  6  zx,nx,zy,ny,f,no = IR[11:6].
- `ex_dest`  out  3  A,D,M write enables = IR[5:3]. Each enable is gated by `ex_valid`.
- `retired`  out  16  count of executed instructions. Wraps mod 2^16.

## Operation
- Internal state:
  - IR (IL bits), `ir_valid`.
  - FSM {RUN, MEXEC}.
  - `retired` counter.
- IR load: on every edge except a stall cycle, IR <= `rom_dout`. `ir_valid` <= 1 except when squashed.
- RUN, IR valid A-instruction:
  - `ex_valid`=1.
  - Stays in RUN.
- RUN, IR valid C-instruction with a=0:
  - `ex_valid`=1.
  - Jump resolves this cycle.
- RUN, IR valid C-instruction with a=1 (M read), first cycle:
  - `ex_valid`=0, `mem_rd`=1, `rom_stall`=1.
  - IR held.
  - FSM -> MEXEC.
  - No jump can occur in this cycle.
- MEXEC:
  - `ex_valid`=1, `mem_rd`=0, `rom_stall`=0.
  - Jump resolves as normal.
  - IR loads `rom_dout`, which is the same word re-presented by the ROM.
  - FSM -> RUN.
- Jump taken:
  - take = `ex_valid` & C-instruction & (j1&`ng` | j2&`zr` | j3&~`zr`&~`ng`), with j1..j3 = IR[2:0].
  - `rom_jmp`=take, `rom_addr`=`a_val`[IL-2:0]. This is the pre-write A value, even if the instruction writes A.
- Squash: on a taken-jump edge, IR loads `rom_dout` (the fall-through word) with `ir_valid` <= 0.
- Invalid IR: `ex_valid`=0, `mem_rd`=0, no jump, no stall.
- `retired` increments on every edge where `ex_valid`=1.
- `rom_stall` and `rom_jmp` are never high together.

## Timing
- Reset (while `a_reset`=1):
  - `rom_jmp`=1, `rom_addr`=0, `rom_stall`=0, `mem_rd`=0, `ex_valid`=0.
  - Edge effects: `ir_valid` <= 0, FSM <= RUN, `retired` <= 0.
- After reset release:
  - First cycle: `rom_dout`=ROM[0], IR invalid.
  - ROM[0] reaches IR at the following edge and executes one cycle later.
- Reset mid-stall (in MEXEC or during a stall cycle): reset dominates and returns the block to RUN with an invalid IR.
- Throughput: 1 instruction/cycle.
  - M-read instruction costs 2 cycles.
  - Taken jump costs exactly 1 bubble.
  - Not-taken jump costs 0 bubbles.
- `rom_jmp`, `rom_addr`, `rom_stall` and `mem_rd` are combinational from IR, FSM, `a_val`, `zr` and `ng`. `ex_*` outputs are combinational from IR.

## Test plan
- Reset held 3 cycles, then released:
  - `rom_jmp`=1 with `rom_addr`=0 throughout reset.
  - First `ex_valid`=1 occurs 2 cycles after release, with ROM[0] in IR.
  - `retired`=0 before that cycle.
- Program `@5`,`@7`,`@9`:
  - `ex_valid` high 3 consecutive cycles.
  - `ex_imm` = 5, 7, 9.
  - `retired`=3.
- `@20`, `0;JMP` followed by filler:
  - `rom_jmp`=1 with `rom_addr`=20 in one cycle.
  - The fall-through word appears with `ex_valid`=0.
  - The next `ex_valid` is ROM[20].
- `D;JEQ` with `zr`=0, `ng`=0:
  - `rom_jmp` stays 0.
  - The next instruction executes with no bubble.
- `D=M` (0xFC10):
  - Cycle 1: `mem_rd`=1, `rom_stall`=1, `ex_valid`=0.
  - Cycle 2: `ex_valid`=1, `ex_sel_m`=1, `ex_dest`=010.
  - The following instruction executes exactly once.
- `D=M;JEQ` with `zr`=1 and `a_val`=0x0030:
  - Stall cycle, then MEXEC with `rom_jmp`=1, `rom_addr`=0x30, one squash bubble.
  - Assert `a_reset` during the stall cycle of a second such instruction: next cycle is the reset state, and `retired` reads 0.
